// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin arbiter that shares one single-port block RAM between two
//   requesters. Requester 0 is the weight loader and requester 1 is the neuron
//   compute engine. The arbiter accepts at most one access (read or write) per
//   cycle and registers the RAM command. Read data returns to the requester
//   that issued the read, marked by a one-cycle valid strobe.
//
// Parameters
//   ADDR_W  RAM address width (depth = 2**ADDR_W words)
//   DATA_W  RAM data width
//   RD_LAT  RAM read latency in clock edges, address-in to douta (1 or 2)
//
// Ports
//   clk                  system clock, rising edge
//   srst                 synchronous active-high reset
//   rN_req / rN_we       request and write-enable of requester N (N = 0, 1)
//   rN_addr / rN_wdata   word address and write data of requester N
//   rN_gnt               combinational grant; a transfer is req & gnt
//   rN_rvalid / rN_rdata read return strobe and data for requester N
//   ram_addr/ram_we/ram_din  registered command to the RAM (ena tied high)
//   ram_dout             RAM read data
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  // One stage for the command register plus RD_LAT stages for the RAM itself.
  localparam int PIPE_D = 1 + RD_LAT;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              ptr_reg;   // 0: requester 0 wins a tie, 1: requester 1 wins
  logic              ptr_next;
  logic              accept;
  logic              sel;       // owner of the accepted transfer
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_we_reg;
  logic [DATA_W-1:0] ram_din_reg;

  logic              tag_valid_reg [PIPE_D];
  logic              tag_owner_reg [PIPE_D];

  assign req = {r1_req, r0_req};

  // Grant decode. Held at zero during reset so nothing is accepted then.
  always_comb begin
    gnt = 2'b00;
    if (!srst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_reg ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign accept    = |gnt;
  assign sel       = gnt[1];
  assign acc_we    = sel ? r1_we    : r0_we;
  assign acc_addr  = sel ? r1_addr  : r0_addr;
  assign acc_wdata = sel ? r1_wdata : r0_wdata;

  // After a transfer the requester that was not granted gets priority:
  // a grant to requester 0 (gnt[0]=1) hands priority to requester 1.
  assign ptr_next = accept ? gnt[0] : ptr_reg;

  // Pointer and RAM command register. Because every access enters this single
  // register in accept order, the RAM sees accesses strictly in that order.
  // A later read of a just-written address therefore returns the new data.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg      <= 1'b0;
      ram_addr_reg <= '0;
      ram_we_reg   <= 1'b0;
      ram_din_reg  <= '0;
    end else begin
      ptr_reg    <= ptr_next;
      ram_we_reg <= accept & acc_we;
      if (accept) begin
        ram_addr_reg <= acc_addr;
        ram_din_reg  <= acc_wdata;
      end
    end
  end

  // Read-return tag pipeline. Stage 0 is loaded together with the command
  // register. The last stage lines up with ram_dout for that read.
  // Reset clears every stage, so reads that are in flight are dropped.
  generate
    for (genvar gi = 0; gi < PIPE_D; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (srst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_owner_reg[gi] <= 1'b0;
          end else begin
            tag_valid_reg[gi] <= accept & ~acc_we;
            tag_owner_reg[gi] <= sel;
          end
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (srst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_owner_reg[gi] <= 1'b0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_owner_reg[gi] <= tag_owner_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];

  // Gated by srst so that no strobe shows during the reset cycle itself.
  assign r0_rvalid = ~srst & tag_valid_reg[PIPE_D-1] & ~tag_owner_reg[PIPE_D-1];
  assign r1_rvalid = ~srst & tag_valid_reg[PIPE_D-1] &  tag_owner_reg[PIPE_D-1];

  // Both ports see the RAM output. Only the strobe says which port owns it.
  assign r0_rdata  = ram_dout;
  assign r1_rdata  = ram_dout;

  assign ram_addr  = ram_addr_reg;
  assign ram_we    = ram_we_reg;
  assign ram_din   = ram_din_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed testbench for ram_arbiter. It runs two instances side by side:
//   instance 0 has RD_LAT=1 and instance 1 has RD_LAT=2. Both instances get
//   identical requester stimulus. Each instance drives its own behavioural RAM.
//   Expected read data comes from a bench-side shadow memory, which is updated
//   on every write the bench expects to be accepted.
module tb_ram_arbiter;

  logic        clk;
  logic        srst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [9:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;

  logic        g0 [2];
  logic        g1 [2];
  logic        v0 [2];
  logic        v1 [2];
  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic [9:0]  cmd_addr [2];
  logic        cmd_we [2];
  logic [31:0] cmd_din [2];
  logic [31:0] rd_out [2];

  int          total = 0;
  int          bad   = 0;
  int          kk;              // cycle index within the current test
  int          exp_g;           // 0 none, 1 r0, 2 r1
  int          ev [2][40];      // expected rvalid owner per instance/cycle
  logic [31:0] ed [2][40];      // expected rdata per instance/cycle
  logic [31:0] shadow [1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] mem [1024];
      logic [31:0] q1, q2;

      ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(gi + 1)) u_dut (
        .clk      (clk),
        .srst     (srst),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_gnt   (g0[gi]),
        .r0_rvalid(v0[gi]),
        .r0_rdata (d0[gi]),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_gnt   (g1[gi]),
        .r1_rvalid(v1[gi]),
        .r1_rdata (d1[gi]),
        .ram_addr (cmd_addr[gi]),
        .ram_we   (cmd_we[gi]),
        .ram_din  (cmd_din[gi]),
        .ram_dout (rd_out[gi])
      );

      // Single-port RAM: one registered read stage, plus an output register
      // when two cycles of latency are wanted.
      always @(posedge clk) begin
        if (cmd_we[gi]) mem[cmd_addr[gi]] <= cmd_din[gi];
        q1 <= mem[cmd_addr[gi]];
        q2 <= q1;
      end
      assign rd_out[gi] = (gi == 0) ? q1 : q2;
    end
  endgenerate

  // Drive one cycle of requests and record what the bench expects to be
  // accepted (eg). Expected reads are scheduled at accept + 1 + RD_LAT.
  task automatic drive(input bit q0, input bit e0, input logic [9:0] a0, input logic [31:0] w0,
                       input bit q1, input bit e1, input logic [9:0] a1, input logic [31:0] w1,
                       input int eg);
    r0_req = q0; r0_we = e0; r0_addr = a0; r0_wdata = w0;
    r1_req = q1; r1_we = e1; r1_addr = a1; r1_wdata = w1;
    exp_g = eg;
    if (eg == 1) begin
      if (e0) shadow[a0] = w0;
      else for (int d = 0; d < 2; d++) begin ev[d][kk+2+d] = 1; ed[d][kk+2+d] = shadow[a0]; end
    end else if (eg == 2) begin
      if (e1) shadow[a1] = w1;
      else for (int d = 0; d < 2; d++) begin ev[d][kk+2+d] = 2; ed[d][kk+2+d] = shadow[a1]; end
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    kk++;
  endtask

  task automatic clear_sched();
    kk = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 40; i++) begin ev[d][i] = 0; ed[d][i] = '0; end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    drive(1, 0, 10'h001, 32'h1, 1, 1, 10'h002, 32'h2, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (g0[d] !== 1'b0 || g1[d] !== 1'b0) begin
        bad++; $display("FAIL rst_gnt lat%0d got r0=%b r1=%b want 0 0", d + 1, g0[d], g1[d]);
      end
      total++;
      if (v0[d] !== 1'b0 || v1[d] !== 1'b0) begin
        bad++; $display("FAIL rst_rvalid lat%0d got r0=%b r1=%b want 0 0", d + 1, v0[d], v1[d]);
      end
      total++;
      if (cmd_we[d] !== 1'b0 || cmd_addr[d] !== 10'h0 || cmd_din[d] !== 32'h0) begin
        bad++; $display("FAIL rst_cmd lat%0d got we=%b addr=%h din=%h want 0 000 00000000",
                        d + 1, cmd_we[d], cmd_addr[d], cmd_din[d]);
      end
    end
    $display("reset: outputs checked");
    srst = 1'b0;
    idle();
    next();
  endtask

  // Only requester 0: two writes then two reads, one access per cycle.
  task automatic test_single_r0();
    clear_sched();
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: drive(1, 1, 10'h000, 32'hA5A5_0001, 0, 0, 10'h0, 32'h0, 1);
        1: drive(1, 1, 10'h3FF, 32'h1234_5678, 0, 0, 10'h0, 32'h0, 1);
        2: drive(1, 0, 10'h000, 32'h0, 0, 0, 10'h0, 32'h0, 1);
        3: drive(1, 0, 10'h3FF, 32'h0, 0, 0, 10'h0, 32'h0, 1);
        default: idle();
      endcase
      for (int d = 0; d < 2; d++) begin
        total++;
        if (g0[d] !== (exp_g == 1) || g1[d] !== (exp_g == 2)) begin
          bad++; $display("FAIL t1_gnt lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, g0[d], g1[d], exp_g);
        end
        total++;
        if (v0[d] !== (ev[d][kk] == 1) || v1[d] !== (ev[d][kk] == 2)) begin
          bad++; $display("FAIL t1_rvalid lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, v0[d], v1[d], ev[d][kk]);
        end
        if (ev[d][kk] != 0) begin
          total++;
          if (d0[d] !== ed[d][kk]) begin
            bad++; $display("FAIL t1_rdata lat%0d k=%0d got %h want %h", d + 1, kk, d0[d], ed[d][kk]);
          end else $display("t1 lat%0d k=%0d r0 read %h", d + 1, kk, d0[d]);
        end
        if (kk == 1) begin
          total++;
          if (cmd_we[d] !== 1'b1 || cmd_addr[d] !== 10'h000 || cmd_din[d] !== 32'hA5A5_0001) begin
            bad++; $display("FAIL t1_cmd lat%0d got we=%b addr=%h din=%h want 1 000 a5a50001",
                            d + 1, cmd_we[d], cmd_addr[d], cmd_din[d]);
          end
        end
        if (kk == 5) begin
          total++;
          if (cmd_we[d] !== 1'b0 || cmd_addr[d] !== 10'h3FF) begin
            bad++; $display("FAIL t1_hold lat%0d got we=%b addr=%h want 0 3ff", d + 1, cmd_we[d], cmd_addr[d]);
          end
        end
      end
      next();
    end
  endtask

  // Both requesters hold a read request for six cycles, starting from a
  // freshly reset pointer. Grants must alternate, beginning with r0.
  task automatic test_contention();
    srst = 1'b1;
    idle();
    next();
    srst = 1'b0;
    clear_sched();
    for (int k = 0; k < 10; k++) begin
      if (k < 6) drive(1, 0, 10'h000, 32'h0, 1, 0, 10'h3FF, 32'h0, (k % 2 == 0) ? 1 : 2);
      else idle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (g0[d] !== (exp_g == 1) || g1[d] !== (exp_g == 2)) begin
          bad++; $display("FAIL t2_gnt lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, g0[d], g1[d], exp_g);
        end
        total++;
        if (v0[d] !== (ev[d][kk] == 1) || v1[d] !== (ev[d][kk] == 2)) begin
          bad++; $display("FAIL t2_rvalid lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, v0[d], v1[d], ev[d][kk]);
        end
        if (ev[d][kk] != 0) begin
          total++;
          if (((ev[d][kk] == 1) ? d0[d] : d1[d]) !== ed[d][kk]) begin
            bad++; $display("FAIL t2_rdata lat%0d k=%0d got r0=%h r1=%h want %h", d + 1, kk, d0[d], d1[d], ed[d][kk]);
          end else $display("t2 lat%0d k=%0d r%0d read %h", d + 1, kk, ev[d][kk] - 1, ed[d][kk]);
        end
      end
      next();
    end
  endtask

  // A write followed by a read of the same address. The first pair crosses
  // requesters; the second pair comes from a single requester.
  task automatic test_fwd();
    clear_sched();
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: drive(0, 0, 10'h0, 32'h0, 1, 1, 10'h010, 32'hDEAD_BEEF, 2);
        1: drive(1, 0, 10'h010, 32'h0, 0, 0, 10'h0, 32'h0, 1);
        2: drive(1, 1, 10'h010, 32'hCAFE_F00D, 0, 0, 10'h0, 32'h0, 1);
        3: drive(1, 0, 10'h010, 32'h0, 0, 0, 10'h0, 32'h0, 1);
        default: idle();
      endcase
      for (int d = 0; d < 2; d++) begin
        total++;
        if (g0[d] !== (exp_g == 1) || g1[d] !== (exp_g == 2)) begin
          bad++; $display("FAIL t3_gnt lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, g0[d], g1[d], exp_g);
        end
        total++;
        if (v0[d] !== (ev[d][kk] == 1) || v1[d] !== (ev[d][kk] == 2)) begin
          bad++; $display("FAIL t3_rvalid lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, v0[d], v1[d], ev[d][kk]);
        end
        if (ev[d][kk] != 0) begin
          total++;
          if (d0[d] !== ed[d][kk]) begin
            bad++; $display("FAIL t3_rdata lat%0d k=%0d got %h want %h", d + 1, kk, d0[d], ed[d][kk]);
          end else $display("t3 lat%0d k=%0d r0 read %h", d + 1, kk, d0[d]);
        end
      end
      next();
    end
  endtask

  // r1 preloads 0x020..0x023 with 0..3, then issues four back-to-back reads.
  task automatic test_back_to_back();
    clear_sched();
    for (int k = 0; k < 13; k++) begin
      if (k < 4)      drive(0, 0, 10'h0, 32'h0, 1, 1, 10'h020 + 10'(k), 32'(k), 2);
      else if (k < 8) drive(0, 0, 10'h0, 32'h0, 1, 0, 10'h020 + 10'(k - 4), 32'h0, 2);
      else            idle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (g0[d] !== (exp_g == 1) || g1[d] !== (exp_g == 2)) begin
          bad++; $display("FAIL t4_gnt lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, g0[d], g1[d], exp_g);
        end
        total++;
        if (v0[d] !== (ev[d][kk] == 1) || v1[d] !== (ev[d][kk] == 2)) begin
          bad++; $display("FAIL t4_rvalid lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, v0[d], v1[d], ev[d][kk]);
        end
        if (ev[d][kk] != 0) begin
          total++;
          if (d1[d] !== ed[d][kk]) begin
            bad++; $display("FAIL t4_rdata lat%0d k=%0d got %h want %h", d + 1, kk, d1[d], ed[d][kk]);
          end else $display("t4 lat%0d k=%0d r1 read %h", d + 1, kk, d1[d]);
        end
      end
      next();
    end
  endtask

  // A read is accepted, then reset is pulsed for one cycle. The read must
  // never return, the command register must clear, and a later tie must go to r0.
  task automatic test_reset_flush();
    clear_sched();
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: begin
          drive(1, 0, 10'h000, 32'h0, 0, 0, 10'h0, 32'h0, 1);
          for (int d = 0; d < 2; d++) for (int i = 0; i < 40; i++) ev[d][i] = 0;
        end
        1: begin
          srst = 1'b1;
          drive(1, 0, 10'h000, 32'h0, 1, 0, 10'h3FF, 32'h0, 0);
        end
        2: begin
          srst = 1'b0;
          idle();
        end
        3: drive(1, 0, 10'h3FF, 32'h0, 1, 0, 10'h000, 32'h0, 1);
        default: idle();
      endcase
      for (int d = 0; d < 2; d++) begin
        total++;
        if (g0[d] !== (exp_g == 1) || g1[d] !== (exp_g == 2)) begin
          bad++; $display("FAIL t5_gnt lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, g0[d], g1[d], exp_g);
        end
        total++;
        if (v0[d] !== (ev[d][kk] == 1) || v1[d] !== (ev[d][kk] == 2)) begin
          bad++; $display("FAIL t5_rvalid lat%0d k=%0d got r0=%b r1=%b want owner %0d", d + 1, kk, v0[d], v1[d], ev[d][kk]);
        end
        if (ev[d][kk] != 0) begin
          total++;
          if (d0[d] !== ed[d][kk]) begin
            bad++; $display("FAIL t5_rdata lat%0d k=%0d got %h want %h", d + 1, kk, d0[d], ed[d][kk]);
          end else $display("t5 lat%0d k=%0d r0 read %h", d + 1, kk, d0[d]);
        end
        if (kk == 2) begin
          total++;
          if (cmd_we[d] !== 1'b0 || cmd_addr[d] !== 10'h0 || cmd_din[d] !== 32'h0) begin
            bad++; $display("FAIL t5_cmd lat%0d got we=%b addr=%h din=%h want 0 000 00000000",
                            d + 1, cmd_we[d], cmd_addr[d], cmd_din[d]);
          end
        end
      end
      next();
    end
  endtask

  initial begin
    srst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    exp_g = 0;
    kk = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    test_reset();
    test_single_r0();
    test_contention();
    test_fwd();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
